button_direction_latch: RTL and testbench

BUTTON_DIRECTION_LATCH -- requirements
Module: button_direction_latch

---
 rtl/button_direction_latch.sv | 72 +++++++
 tb/tb_button_direction_latch.sv | 99 +++++++++
 2 files changed

// File: rtl/button_direction_latch.sv
// button_direction_latch: synchronises and debounces four push-buttons, then latches
// the highest-priority press as a direction code unless it reverses the current one.
module button_direction_latch #(
   parameter int DEBOUNCE_CYCLES = 290000,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       BTNU,
   input  logic       BTNR,
   input  logic       BTND,
   input  logic       BTNL,
   input  logic       rd_ack,
   input  logic       sync_clear,
   output logic [2:0] button_reg,
   output logic       dir_valid
);
   // bit order 0..3 = up, right, down, left, matching the priority order
   logic [3:0] raw, sync1, sync2, stable, press;
   logic [CNT_W-1:0] cnt [4];
   logic [2:0] code;
   logic opposite, accept;
   assign raw = {BTNL, BTND, BTNR, BTNU};
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end
   // press is registered on the flip edge so the output can load one edge later
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable <= '0;
         press  <= '0;
         for (int b = 0; b < 4; b++) cnt[b] <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            press[b] <= 1'b0;
            if (sync2[b] == stable[b]) cnt[b] <= '0;
            else if (cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               cnt[b]    <= '0;
               stable[b] <= ~stable[b];
               press[b]  <= ~stable[b];
            end else cnt[b] <= cnt[b] + 1'b1;
         end
      end
   end
   always_comb begin
      code = press[0] ? 3'd1 :
             press[1] ? 3'd2 :
             press[2] ? 3'd3 :
             press[3] ? 3'd4 : 3'd0;
      opposite = (code == 3'd1 && button_reg == 3'd3) || (code == 3'd3 && button_reg == 3'd1) ||
                 (code == 3'd2 && button_reg == 3'd4) || (code == 3'd4 && button_reg == 3'd2);
      accept = (code != 3'd0) && !opposite;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         button_reg <= 3'd0;
         dir_valid  <= 1'b0;
      end else if (sync_clear) begin
         button_reg <= 3'd0;
         dir_valid  <= 1'b0;
      end else if (accept) begin
         button_reg <= code;
         dir_valid  <= 1'b1;
      end else if (rd_ack) dir_valid <= 1'b0;
   end
endmodule

// File: tb/tb_button_direction_latch.sv
// tb_button_direction_latch: directed stimulus pushes expected output changes (value and
// cycle) into a queue; a negedge monitor pops one entry per observed output change.
module tb_button_direction_latch;
   logic clock = 1'b0, reset = 1'b1;
   logic BTNU = 1'b0, BTNR = 1'b0, BTND = 1'b0, BTNL = 1'b0, rd_ack = 1'b0, sync_clear = 1'b0;
   logic [2:0] button_reg;
   logic dir_valid;
   int cyc = 0, checks = 0, errors = 0;
   typedef struct { logic [2:0] r; logic v; int c; } exp_t;
   exp_t q[$];
   logic [3:0] last = 4'b0000;
   button_direction_latch #(.DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .BTNU(BTNU), .BTNR(BTNR), .BTND(BTND), .BTNL(BTNL),
      .rd_ack(rd_ack), .sync_clear(sync_clear), .button_reg(button_reg), .dir_valid(dir_valid)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      exp_t e;
      if ({button_reg, dir_valid} !== last) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change got reg=%0d valid=%0d cycle=%0d required no change",
                     button_reg, dir_valid, cyc);
         end else begin
            e = q.pop_front();
            if (button_reg !== e.r || dir_valid !== e.v || cyc != e.c) begin
               errors++;
               $display("FAIL output_change got reg=%0d valid=%0d cycle=%0d required reg=%0d valid=%0d cycle=%0d",
                        button_reg, dir_valid, cyc, e.r, e.v, e.c);
            end
         end
         last = {button_reg, dir_valid};
      end
   end
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic expect_out(input logic [2:0] r, input logic v, input int c);
      q.push_back('{r: r, v: v, c: c});
   endtask
   task automatic chk(input string n, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", n, act, req);
      end
   endtask
   initial begin
      step(3);
      chk("reset_reg", int'(button_reg), 0);
      chk("reset_valid", int'(dir_valid), 0);
      reset = 1'b0;
      step(2);
      // bounce: 3 high / 1 low never reaches the 4-cycle threshold
      for (int k = 0; k < 4; k++) begin
         BTND = 1'b1; step(3);
         BTND = 1'b0; step(1);
      end
      step(10);
      chk("bounce_reg", int'(button_reg), 0);
      chk("bounce_valid", int'(dir_valid), 0);
      // up press: 7-edge latency, then rd_ack clears valid only
      BTNU = 1'b1; expect_out(3'd1, 1'b1, cyc + 7);
      step(10); BTNU = 1'b0; step(8);
      expect_out(3'd1, 1'b0, cyc + 1); rd_ack = 1'b1; step(1); rd_ack = 1'b0; step(2);
      // down reverses up: rejected; right accepted
      BTND = 1'b1; step(10); BTND = 1'b0; step(8);
      chk("reverse_reg", int'(button_reg), 1);
      BTNR = 1'b1; expect_out(3'd2, 1'b1, cyc + 7);
      step(10); BTNR = 1'b0; step(8);
      // clear, then up and left together: up wins
      expect_out(3'd0, 1'b0, cyc + 1); sync_clear = 1'b1; step(1); sync_clear = 1'b0; step(2);
      BTNU = 1'b1; BTNL = 1'b1; expect_out(3'd1, 1'b1, cyc + 7);
      step(10); BTNU = 1'b0; BTNL = 1'b0; step(8);
      // left accepted on the rd_ack edge, then sync_clear
      BTNL = 1'b1; expect_out(3'd4, 1'b1, cyc + 7);
      step(6); rd_ack = 1'b1; step(1); rd_ack = 1'b0;
      expect_out(3'd0, 1'b0, cyc + 1); sync_clear = 1'b1; step(1); sync_clear = 1'b0;
      step(4); BTNL = 1'b0; step(8);
      // reset mid-debounce with the button released during reset
      BTNU = 1'b1; expect_out(3'd1, 1'b1, cyc + 7);
      step(10); BTNU = 1'b0; step(8);
      BTNR = 1'b1; step(4);
      expect_out(3'd0, 1'b0, cyc); reset = 1'b1; BTNR = 1'b0;
      step(2); reset = 1'b0; step(20);
      chk("abandon_reg", int'(button_reg), 0);
      // button held across reset is a fresh press
      BTNL = 1'b1; step(2); reset = 1'b1; step(2); reset = 1'b0;
      expect_out(3'd4, 1'b1, cyc + 7);
      step(12); BTNL = 1'b0; step(8);
      for (int k = 0; k < 20 && q.size() != 0; k++) step(1);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
